// File: rtl/change_dispenser_if.sv
// Signal bundle between the vending FSM, the change dispenser and the coin-hopper drivers.
// The master side issues refund requests and reports hopper status; the slave side is the dispenser.
interface change_dispenser_if #(
    parameter int AMOUNT_WIDTH = 6,
    parameter int COUNT_WIDTH  = 4
);
    logic                    start;
    logic [AMOUNT_WIDTH-1:0] refundAmount;
    logic                    hopperReady;
    logic                    emptyFive;
    logic                    emptyTen;
    logic                    emptyTwenty;
    logic                    ejectFive;
    logic                    ejectTen;
    logic                    ejectTwenty;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic [AMOUNT_WIDTH-1:0] shortfall;
    logic [COUNT_WIDTH-1:0]  coinCount;

    modport master (
        output start, refundAmount, hopperReady, emptyFive, emptyTen, emptyTwenty,
        input  ejectFive, ejectTen, ejectTwenty, busy, done, error, shortfall, coinCount
    );

    modport slave (
        input  start, refundAmount, hopperReady, emptyFive, emptyTen, emptyTwenty,
        output ejectFive, ejectTen, ejectTwenty, busy, done, error, shortfall, coinCount
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin-change transmitter: pays a refund in 20/10/5 rupee coins, largest available first,
// pacing eject pulses on the hopper ready line and reporting coins issued and any undelivered amount.
module change_dispenser #(
    parameter int AMOUNT_WIDTH = 6,
    parameter int COUNT_WIDTH  = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic              clock,
    input  logic              reset,
    change_dispenser_if.slave bus
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE} state_t;
    typedef enum logic [1:0] {COIN_NONE, COIN_5, COIN_10, COIN_20} coin_t;

    state_t                  state, state_next;
    coin_t                   coin, pick;
    logic [AMOUNT_WIDTH-1:0] remaining;
    logic [AMOUNT_WIDTH-1:0] amount_mod;
    logic [AMOUNT_WIDTH-1:0] coin_value;
    logic [2:0]              odd_part;
    logic [GAP_W-1:0]        gap_cnt;
    logic [COUNT_WIDTH-1:0]  coin_count;
    logic [AMOUNT_WIDTH-1:0] shortfall_q;
    logic                    error_q;

    assign amount_mod = bus.refundAmount % AMOUNT_WIDTH'(5);

    // Largest coin that both fits the remaining amount and has stock; re-evaluated every cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick = COIN_NONE;
        if (!bus.emptyTwenty && remaining >= AMOUNT_WIDTH'(20))
            pick = COIN_20;
        else if (!bus.emptyTen && remaining >= AMOUNT_WIDTH'(10))
            pick = COIN_10;
        else if (!bus.emptyFive && remaining >= AMOUNT_WIDTH'(5))
            pick = COIN_5;
    end

    always_comb begin
        coin_value = '0;
        case (coin)
            COIN_20: coin_value = AMOUNT_WIDTH'(20);
            COIN_10: coin_value = AMOUNT_WIDTH'(10);
            COIN_5:  coin_value = AMOUNT_WIDTH'(5);
            default: coin_value = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (bus.start) state_next = SELECT;
            SELECT: begin
                if (remaining == '0 || pick == COIN_NONE) state_next = DONE;
                else if (bus.hopperReady)                 state_next = EJECT;
            end
            EJECT:  state_next = GAP;
            GAP:    if (gap_cnt == '0) state_next = SELECT;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            coin        <= COIN_NONE;
            remaining   <= '0;
            odd_part    <= '0;
            gap_cnt     <= '0;
            coin_count  <= '0;
            shortfall_q <= '0;
            error_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    remaining   <= bus.refundAmount - amount_mod;
                    odd_part    <= 3'(amount_mod);
                    coin_count  <= '0;
                    shortfall_q <= '0;
                    error_q     <= 1'b0;
                end
                SELECT: begin
                    if (state_next == EJECT) coin <= pick;
                    if (state_next == DONE) begin
                        shortfall_q <= remaining + AMOUNT_WIDTH'(odd_part);
                        error_q     <= (remaining + AMOUNT_WIDTH'(odd_part)) != '0;
                    end
                end
                EJECT: begin
                    remaining <= remaining - coin_value;
                    if (coin_count != '1) coin_count <= coin_count + 1'b1;
                    gap_cnt   <= GAP_W'(GAP_CYCLES - 1);
                end
                GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // All outputs decode registered state, so reset clears them without waiting for a clock.
    assign bus.ejectTwenty = (state == EJECT) && (coin == COIN_20);
    assign bus.ejectTen    = (state == EJECT) && (coin == COIN_10);
    assign bus.ejectFive   = (state == EJECT) && (coin == COIN_5);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.error       = error_q;
    assign bus.shortfall   = shortfall_q;
    assign bus.coinCount   = coin_count;
endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random refunds compared
// against a greedy change-making model and a pulse-timing model.
module tb_change_dispenser;
    localparam int AW  = 6;
    localparam int CW  = 4;
    localparam int GAP = 2;

    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_coins[$];
    int   exp_short;

    change_dispenser_if #(.AMOUNT_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

    change_dispenser #(.AMOUNT_WIDTH(AW), .COUNT_WIDTH(CW), .GAP_CYCLES(GAP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Greedy change-making: repeatedly hand out the biggest stocked coin that still fits.
    task automatic build_model(input int amt, input bit e5, input bit e10, input bit e20);
        int left;
        exp_coins.delete();
        left = amt - (amt % 5);
        forever begin
            if      (left >= 20 && !e20) begin exp_coins.push_back(20); left -= 20; end
            else if (left >= 10 && !e10) begin exp_coins.push_back(10); left -= 10; end
            else if (left >= 5  && !e5)  begin exp_coins.push_back(5);  left -= 5;  end
            else break;
        end
        exp_short = left + (amt % 5);
    endtask

    function automatic logic [31:0] all_outputs();
        return {20'd0, bus.ejectTwenty, bus.ejectTen, bus.ejectFive, bus.busy, bus.done, bus.error,
                bus.shortfall};
    endfunction

    task automatic run_txn(input string name, input int amt, input bit e5, input bit e10, input bit e20);
        int got[$];
        int at[$];
        int onehot_bad = 0;
        int busy_bad   = 0;
        int done_at    = -1;
        build_model(amt, e5, e10, e20);
        @(negedge clock);
        bus.emptyFive    = e5;
        bus.emptyTen     = e10;
        bus.emptyTwenty  = e20;
        bus.hopperReady  = 1'b1;
        bus.refundAmount = AW'(amt);
        bus.start        = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        for (int c = 0; c < 300 && done_at < 0; c++) begin
            @(negedge clock);
            if ($countones({bus.ejectTwenty, bus.ejectTen, bus.ejectFive}) > 1) onehot_bad++;
            if (bus.ejectTwenty) begin got.push_back(20); at.push_back(c); end
            if (bus.ejectTen)    begin got.push_back(10); at.push_back(c); end
            if (bus.ejectFive)   begin got.push_back(5);  at.push_back(c); end
            if (!bus.busy) busy_bad++;
            if (bus.done) begin
                done_at = c;
                check($sformatf("%s error", name), 32'(bus.error), 32'(exp_short != 0));
                check($sformatf("%s shortfall", name), 32'(bus.shortfall), 32'(exp_short));
                check($sformatf("%s coinCount", name), 32'(bus.coinCount), 32'(exp_coins.size()));
            end
        end
        check($sformatf("%s done_seen", name), 32'(done_at >= 0), 32'd1);
        check($sformatf("%s num_coins", name), 32'(got.size()), 32'(exp_coins.size()));
        for (int i = 0; i < exp_coins.size(); i++) begin
            check($sformatf("%s coin%0d value", name, i), 32'(got[i]), 32'(exp_coins[i]));
            check($sformatf("%s coin%0d cycle", name, i), 32'(at[i]), 32'(1 + i * (GAP + 2)));
        end
        check($sformatf("%s done_cycle", name), 32'(done_at), 32'(exp_coins.size() * (GAP + 2) + 1));
        check($sformatf("%s onehot", name), 32'(onehot_bad), 32'd0);
        check($sformatf("%s busy_during", name), 32'(busy_bad), 32'd0);
        @(negedge clock);
        check($sformatf("%s idle_after", name), 32'(bus.busy), 32'd0);
        check($sformatf("%s error_held", name), 32'(bus.error), 32'(exp_short != 0));
        check($sformatf("%s shortfall_held", name), 32'(bus.shortfall), 32'(exp_short));
    endtask

    initial begin
        int ejects;
        int busy_bad;
        int done_seen;
        reset            = 1'b0;
        bus.start        = 1'b0;
        bus.refundAmount = '0;
        bus.hopperReady  = 1'b1;
        bus.emptyFive    = 1'b0;
        bus.emptyTen     = 1'b0;
        bus.emptyTwenty  = 1'b0;
        #1;
        check("reset outputs", all_outputs(), 32'd0);
        check("reset coinCount", 32'(bus.coinCount), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        run_txn("refund35", 35, 0, 0, 0);
        run_txn("refund23", 23, 0, 0, 0);
        run_txn("no20_refund40", 40, 0, 0, 1);
        run_txn("refund15_no10_no5", 15, 1, 1, 0);
        run_txn("refund0", 0, 0, 0, 0);
        run_txn("refund63", 63, 0, 0, 0);

        // Hopper not ready: dispenser must sit in SELECT and ignore further start requests.
        @(negedge clock);
        bus.hopperReady  = 1'b0;
        bus.refundAmount = AW'(20);
        bus.start        = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        ejects = 0; busy_bad = 0; done_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            ejects    += $countones({bus.ejectTwenty, bus.ejectTen, bus.ejectFive});
            busy_bad  += (bus.busy ? 0 : 1);
            done_seen += (bus.done ? 1 : 0);
            bus.start        = c[0];
            bus.refundAmount = AW'(55);
        end
        check("stall ejects", 32'(ejects), 32'd0);
        check("stall busy", 32'(busy_bad), 32'd0);
        check("stall done", 32'(done_seen), 32'd0);
        bus.start       = 1'b0;
        bus.hopperReady = 1'b1;
        @(negedge clock);
        check("stall release eject20", 32'(bus.ejectTwenty), 32'd1);
        done_seen = 0;
        for (int c = 0; c < 50 && done_seen == 0; c++) begin
            @(negedge clock);
            if (bus.done) begin
                done_seen = 1;
                check("stall coinCount", 32'(bus.coinCount), 32'd1);
                check("stall shortfall", 32'(bus.shortfall), 32'd0);
                check("stall error", 32'(bus.error), 32'd0);
            end
        end
        check("stall done_seen", 32'(done_seen), 32'd1);
        @(negedge clock);

        // Asynchronous reset in the middle of an eject pulse.
        @(negedge clock);
        bus.refundAmount = AW'(25);
        bus.start        = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        repeat (6) @(negedge clock);
        check("midreset eject5 before", 32'(bus.ejectFive), 32'd1);
        check("midreset count before", 32'(bus.coinCount), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midreset outputs", all_outputs(), 32'd0);
        check("midreset coinCount", 32'(bus.coinCount), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post reset idle", 32'(bus.busy), 32'd0);
        run_txn("post_reset10", 10, 0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            run_txn($sformatf("rand%0d", r), int'($urandom_range(0, 63)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
